// File: rtl/sensor_uart_pkg.sv
// Shared types and constants for the sensor-to-UART packetizer.
// Optional macro SENSOR_PKT_CHECKSUM_EN appends a CHK byte to each frame.
package sensor_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT
  } pkt_state_e;

  localparam logic [7:0] PKT_SYNC_DEFAULT = 8'hAA;

  typedef logic [15:0] sample_t;

  function automatic int unsigned pkt_frame_len();
`ifdef SENSOR_PKT_CHECKSUM_EN
    return 5;
`else
    return 4;
`endif
  endfunction

endpackage

// File: rtl/sensor_uart_packetizer_fifo.sv
// Synchronous sample FIFO: push/pop, full/empty flags and occupancy level.
// Ports: clk, rst_n, push, pop, wdata, rdata, full, empty, level.
module pkt_sample_fifo
  import sensor_uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  sample_t                  wdata,
  output sample_t                  rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  sample_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sensor_uart_packetizer.sv
// Frames 16-bit samples as SYNC,SEQ,HI,LO[,CHK] and feeds uart_top TX.
// Ports: sample in/ready, ovf_clr, tx_* handshake, frame_done, overflow,
// fifo_level. Macro SENSOR_PKT_CHECKSUM_EN adds the CHK byte.
module sensor_uart_packetizer
  import sensor_uart_pkg::*;
#(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] SYNC_BYTE  = PKT_SYNC_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sample_valid,
  input  logic [15:0]                   sample_data,
  output logic                          sample_ready,
  input  logic                          ovf_clr,
  output logic                          tx_start,
  output logic [7:0]                    tx_data,
  input  logic                          tx_busy,
  input  logic                          tx_done,
  output logic                          frame_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam logic [2:0] LAST = 3'(pkt_frame_len() - 1);

  pkt_state_e  state;
  pkt_state_e  state_nx;
  sample_t     sample_q;
  sample_t     fifo_rdata;
  logic [7:0]  seq_q;
  logic [2:0]  byte_idx;
  logic [7:0]  cur_byte;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
`ifdef SENSOR_PKT_CHECKSUM_EN
  logic [7:0]  chk_q;
`endif

  assign push         = sample_valid && !full;
  assign pop          = (state == LOAD);
  assign sample_ready = !full;

  pkt_sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (sample_data),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (sample_valid && full) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  always_comb begin
    cur_byte = SYNC_BYTE;
    case (byte_idx)
      3'd0:    cur_byte = SYNC_BYTE;
      3'd1:    cur_byte = seq_q;
      3'd2:    cur_byte = sample_q[15:8];
      3'd3:    cur_byte = sample_q[7:0];
`ifdef SENSOR_PKT_CHECKSUM_EN
      default: cur_byte = chk_q;
`else
      default: cur_byte = 8'h00;
`endif
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sample_q <= '0;
      seq_q    <= '0;
      byte_idx <= '0;
`ifdef SENSOR_PKT_CHECKSUM_EN
      chk_q    <= '0;
`endif
    end else begin
      state <= state_nx;
      if (state == LOAD) begin
        sample_q <= fifo_rdata;
        byte_idx <= '0;
`ifdef SENSOR_PKT_CHECKSUM_EN
        chk_q    <= seq_q ^ fifo_rdata[15:8] ^ fifo_rdata[7:0];
`endif
      end
      if (state == WAIT && tx_done) begin
        if (byte_idx == LAST) seq_q <= seq_q + 8'd1;
        else                  byte_idx <= byte_idx + 3'd1;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    tx_start   = 1'b0;
    tx_data    = 8'h00;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) state_nx = LOAD;
      end
      LOAD: begin
        state_nx = SEND;
      end
      SEND: begin
        tx_data = cur_byte;
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        tx_data = cur_byte;
        if (tx_done) begin
          if (byte_idx == LAST) begin
            frame_done = 1'b1;
            state_nx   = IDLE;
          end else begin
            state_nx = SEND;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sensor_uart_packetizer.sv
// Directed bench for sensor_uart_packetizer with a small uart_top stand-in.
// Honors SENSOR_PKT_CHECKSUM_EN for the expected frame length.
module tb_sensor_uart_packetizer;

`ifdef SENSOR_PKT_CHECKSUM_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_data = '0;
  logic        sample_ready;
  logic        ovf_clr = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_done = 1'b0;
  logic        frame_done;
  logic        overflow;
  logic [3:0]  fifo_level;

  logic        model_busy = 1'b0;
  logic        busy_force = 1'b0;
  logic        uart_en = 1'b1;

  int          vectors = 0;
  int          miscompares = 0;
  int          fd_cnt = 0;
  logic [7:0]  rxq[$];
  logic [15:0] expq[$];

  assign tx_busy = model_busy | busy_force;

  always #5 clk = ~clk;

  sensor_uart_packetizer #(
    .FIFO_DEPTH (8),
    .SYNC_BYTE  (8'hAA)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ready (sample_ready),
    .ovf_clr      (ovf_clr),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .frame_done   (frame_done),
    .overflow     (overflow),
    .fifo_level   (fifo_level)
  );

  // uart_top stand-in: busy for a few cycles, then a one-cycle done.
  initial forever begin
    @(negedge clk);
    if (uart_en && tx_start) begin
      rxq.push_back(tx_data);
      @(posedge clk);
      #1 model_busy = 1'b1;
      repeat (3) @(posedge clk);
      #1 model_busy = 1'b0;
      tx_done = 1'b1;
      @(posedge clk);
      #1 tx_done = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (frame_done) fd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [7:0] seq,
                                          input logic [15:0] d,
                                          input int b);
    case (b)
      0:       return 8'hAA;
      1:       return seq;
      2:       return d[15:8];
      3:       return d[7:0];
      default: return seq ^ d[15:8] ^ d[7:0];
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_fifo_level"}, fifo_level, 0);
    chk({tag, "_sample_ready"}, sample_ready, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    busy_force = 1'b0;
    sample_valid = 1'b0;
    ovf_clr = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b1;
    rxq.delete();
    expq.delete();
    fd_cnt = 0;
  endtask

  task automatic push(input logic [15:0] d);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data = d;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c = 0;
    while (fd_cnt < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("frame_wait", fd_cnt >= n, 1);
  endtask

  task automatic check_frames(input string tag, input logic [7:0] seq0,
                              input int nf);
    chk({tag, "_byte_count"}, rxq.size(), nf * FL);
    for (int f = 0; f < nf; f++) begin
      for (int b = 0; b < FL; b++) begin
        if (f * FL + b < rxq.size() && f < expq.size())
          chk($sformatf("%s_f%0d_b%0d", tag, f, b), rxq[f*FL+b],
              exp_byte(seq0 + 8'(f), expq[f], b));
      end
    end
  endtask

  initial begin
    int starts;
    int g;
    logic [15:0] d;

    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // single sample: latency and frame content
    sample_valid = 1'b1;
    sample_data = 16'h1234;
    expq.push_back(16'h1234);
    @(negedge clk);
    sample_valid = 1'b0;
    chk("lvl_after_push", fifo_level, 1);
    chk("no_start_idle", tx_start, 0);
    @(negedge clk);
    chk("no_start_load", tx_start, 0);
    @(negedge clk);
    #1;
    chk("start_at_n2", tx_start, 1);
    chk("sync_byte", tx_data, 8'hAA);
    wait_frames(1, 200);
    repeat (20) @(negedge clk);
    chk("one_frame_done", fd_cnt, 1);
    check_frames("single", 8'h00, 1);

    // burst of 10 into depth 8, drop + clear collide on the last one
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample_data = 16'hA000 + 16'(i);
      ovf_clr = (i == 9);
      if (i < 9) expq.push_back(16'hA000 + 16'(i));
    end
    @(negedge clk);
    sample_valid = 1'b0;
    ovf_clr = 1'b0;
    chk("ovf_set_wins", overflow, 1);
    chk("burst_level", fifo_level, 8);
    chk("burst_not_ready", sample_ready, 0);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_cleared", overflow, 0);
    wait_frames(9, 2000);
    repeat (40) @(negedge clk);
    check_frames("burst", 8'h00, 9);

    // tx_busy held: no start, stable data, one pulse on release
    do_reset();
    uart_en = 1'b0;
    busy_force = 1'b1;
    push(16'h5AA5);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("busy_no_start", tx_start, 0);
      chk("busy_data", tx_data, 8'hAA);
    end
    busy_force = 1'b0;
    #1;
    chk("release_start", tx_start, 1);
    starts = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx_start) starts++;
    end
    chk("extra_starts", starts, 0);
    chk("wait_data", tx_data, 8'hAA);
    uart_en = 1'b1;

    // reset during DATA_HI with a second sample queued
    do_reset();
    push(16'hBEEF);
    push(16'h5555);
    g = 0;
    while (rxq.size() < 3 && g < 500) begin
      @(negedge clk);
      #2;
      g++;
    end
    chk("hi_seen", rxq.size(), 3);
    chk("hi_byte", rxq[2], 8'hBE);
    chk("hi_level", fifo_level, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (8) @(negedge clk);
    rst_n = 1'b1;
    rxq.delete();
    expq.delete();
    fd_cnt = 0;
    push(16'h0F0F);
    expq.push_back(16'h0F0F);
    wait_frames(1, 200);
    repeat (20) @(negedge clk);
    check_frames("post_rst", 8'h00, 1);

    // 257-sample stream: SEQ wraps, every byte checked
    do_reset();
    for (int i = 0; i < 257; i++) begin
      d = 16'h5A3C ^ 16'(i * 16'h0101);
      g = 0;
      @(negedge clk);
      while (!sample_ready && g < 1000) begin
        @(negedge clk);
        g++;
      end
      sample_valid = 1'b1;
      sample_data = d;
      expq.push_back(d);
      @(negedge clk);
      sample_valid = 1'b0;
    end
    wait_frames(257, 20000);
    repeat (40) @(negedge clk);
    check_frames("stream", 8'h00, 257);
    if (rxq.size() > 256 * FL + 1)
      chk("seq_wrap", rxq[256*FL+1], 8'h00);
    else
      chk("seq_wrap_len", rxq.size(), 257 * FL);
    chk("stream_ovf", overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
